// File: rtl/mod_exp_ladder_ctrl.sv
// mod_exp_ladder_ctrl: owns the operand stores and sequences an external
// word-serial Montgomery-product engine to compute c^d mod n, in either a
// constant-time Montgomery-ladder mode or a square-and-multiply mode.
// Operands load and the result drains over valid/ready word streams.
module mod_exp_ladder_ctrl #(
  parameter int WORD_W    = 128,
  parameter int NUM_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_in_sel,
  input  logic [WORD_W-1:0] i_in_data,
  input  logic              i_start,
  input  logic              i_mode,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WORD_W-1:0] o_out_data,
  output logic              o_mp_start,
  output logic              o_mp_op_valid,
  output logic [WORD_W-1:0] o_mp_a,
  output logic [WORD_W-1:0] o_mp_b,
  input  logic              i_mp_res_valid,
  input  logic [WORD_W-1:0] i_mp_res
);
  localparam int EXP_BITS = WORD_W * NUM_WORDS;
  localparam int PW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int IW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [PW-1:0] LAST_W  = PW'(NUM_WORDS - 1);
  localparam logic [IW-1:0] TOP_BIT = IW'(EXP_BITS - 1);

  typedef enum logic [3:0] {S_IDLE, S_CBAR, S_LAD_A, S_LAD_B, S_SCAN,
                            S_SQR, S_MUL, S_CONV, S_DONE} state_t;
  typedef enum logic [2:0] {SRC_C, SRC_T, SRC_R0, SRC_R1, SRC_ONE} src_t;
  // One product op: two operand sources and the destination (R0 or R1/cbar)
  typedef struct packed { src_t a; src_t b; logic dst_r1; } op_t;
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] opnd_t;

  // R0 lives in the r store; R1 and cbar share one store, since the ladder
  // starts R1 at cbar and square-and-multiply only ever reads cbar.
  opnd_t r_st_c, r_st_d, r_st_t, r_st_r, r_st_x;

  state_t              r_state, w_nxt;
  op_t                 r_op;
  logic                r_cap, r_mode, r_b, w_nb, w_go;
  logic [IW-1:0]       r_idx, w_nidx;
  logic [PW-1:0]       r_op_ptr, r_res_ptr, r_out_ptr;
  logic [3:0][PW-1:0]  r_ld_ptr;
  logic [3:0]          r_loaded;
  logic                r_in_ready, r_busy, r_err, r_out_valid;
  logic                r_mp_start, r_mp_op_valid;
  logic [WORD_W-1:0]   r_mp_a, r_mp_b, w_a, w_b;
  logic [EXP_BITS-1:0] w_d_flat;
  logic                w_idle, w_ld, w_cap, w_op_done, w_start_ok, w_bit, w_bit_dn;

  assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_ld       = i_in_valid && r_in_ready;
  assign w_cap      = r_cap && i_mp_res_valid;
  assign w_op_done  = w_cap && (r_res_ptr == LAST_W);
  assign w_start_ok = w_idle && i_start && (&r_loaded);
  assign w_d_flat   = r_st_d;
  assign w_bit      = w_d_flat[r_idx];
  assign w_bit_dn   = w_d_flat[r_idx - 1'b1];

  assign o_in_ready    = r_in_ready;
  assign o_busy        = r_busy;
  assign o_err         = r_err;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_valid ? r_st_r[r_out_ptr] : '0;
  assign o_mp_start    = r_mp_start;
  assign o_mp_op_valid = r_mp_op_valid;
  assign o_mp_a        = r_mp_a;
  assign o_mp_b        = r_mp_b;

  function automatic logic [PW-1:0] f_inc(logic [PW-1:0] p);
    return (p == LAST_W) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [WORD_W-1:0] f_word(src_t s, logic [PW-1:0] p);
    logic [WORD_W-1:0] w;
    case (s)
      SRC_C:   w = r_st_c[p];
      SRC_T:   w = r_st_t[p];
      SRC_R0:  w = r_st_r[p];
      SRC_R1:  w = r_st_x[p];
      SRC_ONE: w = (p == '0) ? WORD_W'(1) : '0;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Operand routing for each op kind; b selects the ladder register pair
  function automatic op_t f_op(state_t s, logic b);
    op_t o;
    o = '{a: SRC_R0, b: SRC_R0, dst_r1: 1'b0};
    case (s)
      S_CBAR:  o = '{a: SRC_C,  b: SRC_T,   dst_r1: 1'b1};
      S_LAD_A: o = '{a: SRC_R0, b: SRC_R1,  dst_r1: ~b};
      S_LAD_B: o = '{a: b ? SRC_R1 : SRC_R0, b: b ? SRC_R1 : SRC_R0, dst_r1: b};
      S_MUL:   o = '{a: SRC_R0, b: SRC_R1,  dst_r1: 1'b0};
      S_CONV:  o = '{a: SRC_R0, b: SRC_ONE, dst_r1: 1'b0};
      default: o = '{a: SRC_R0, b: SRC_R0,  dst_r1: 1'b0};
    endcase
    return o;
  endfunction

  // Operand words presented to the engine at the current op pointer
  always_comb begin
    w_a = f_word(r_op.a, r_op_ptr);
    w_b = f_word(r_op.b, r_op_ptr);
  end

  // Sequencing decisions: next state, bit index, and whether a new op issues
  always_comb begin
    w_go = 1'b0; w_nxt = r_state; w_nidx = r_idx; w_nb = r_b;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) begin w_go = 1'b1; w_nxt = S_CBAR; end
      S_SCAN: begin
        if (w_bit)              begin w_go = 1'b1; w_nxt = S_SQR;  end
        else if (r_idx == '0)   begin w_go = 1'b1; w_nxt = S_CONV; end
        else                    w_nidx = r_idx - 1'b1;
      end
      default: if (w_op_done) begin
        case (r_state)
          S_CBAR: begin
            w_nidx = TOP_BIT;
            if (r_mode) w_nxt = S_SCAN;
            else begin w_go = 1'b1; w_nxt = S_LAD_A; w_nb = w_d_flat[TOP_BIT]; end
          end
          S_LAD_A: begin w_go = 1'b1; w_nxt = S_LAD_B; end
          S_LAD_B: begin
            w_go = 1'b1;
            if (r_idx == '0) w_nxt = S_CONV;
            else begin w_nxt = S_LAD_A; w_nidx = r_idx - 1'b1; w_nb = w_bit_dn; end
          end
          S_SQR: begin
            w_go = 1'b1;
            if (w_bit)             w_nxt = S_MUL;
            else if (r_idx == '0)  w_nxt = S_CONV;
            else begin w_nxt = S_SQR; w_nidx = r_idx - 1'b1; end
          end
          S_MUL: begin
            w_go = 1'b1;
            if (r_idx == '0) w_nxt = S_CONV;
            else begin w_nxt = S_SQR; w_nidx = r_idx - 1'b1; end
          end
          S_CONV:  w_nxt = S_DONE;
          default: w_nxt = S_IDLE;
        endcase
      end
    endcase
  end

  // Control FSM, product-op streaming, load bookkeeping and result drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE; r_idx <= '0; r_b <= 1'b0; r_mode <= 1'b0;
      r_op <= '{a: SRC_C, b: SRC_C, dst_r1: 1'b0};
      r_cap <= 1'b0; r_op_ptr <= '0; r_res_ptr <= '0; r_out_ptr <= '0;
      r_ld_ptr <= '0; r_loaded <= '0;
      r_in_ready <= 1'b0; r_busy <= 1'b0; r_err <= 1'b0; r_out_valid <= 1'b0;
      r_mp_start <= 1'b0; r_mp_op_valid <= 1'b0; r_mp_a <= '0; r_mp_b <= '0;
    end else begin
      r_state    <= w_nxt;
      r_idx      <= w_nidx;
      r_b        <= w_nb;
      r_in_ready <= (w_nxt == S_IDLE) || (w_nxt == S_DONE);
      r_busy     <= !((w_nxt == S_IDLE) || (w_nxt == S_DONE));
      r_err      <= w_idle && i_start && !(&r_loaded);
      if (w_ld) begin
        r_ld_ptr[i_in_sel] <= f_inc(r_ld_ptr[i_in_sel]);
        if (r_ld_ptr[i_in_sel] == LAST_W) r_loaded[i_in_sel] <= 1'b1;
      end
      // start pulse, then NUM_WORDS operand words, then the capture window
      if (w_go) begin
        r_mp_start <= 1'b1; r_op <= f_op(w_nxt, w_nb);
        r_op_ptr <= '0; r_res_ptr <= '0; r_cap <= 1'b0;
      end else if (r_mp_start || r_mp_op_valid) begin
        r_mp_start <= 1'b0;
        if (r_mp_op_valid && (r_op_ptr == '0)) begin
          r_mp_op_valid <= 1'b0; r_mp_a <= '0; r_mp_b <= '0; r_cap <= 1'b1;
        end else begin
          r_mp_op_valid <= 1'b1; r_mp_a <= w_a; r_mp_b <= w_b;
          r_op_ptr <= f_inc(r_op_ptr);
        end
      end else if (w_cap) begin
        r_res_ptr <= f_inc(r_res_ptr);
        if (w_op_done) r_cap <= 1'b0;
      end
      if (w_op_done && (r_state == S_CONV)) begin
        r_out_valid <= 1'b1; r_out_ptr <= '0;
      end else if (r_out_valid && i_out_ready) begin
        if (r_out_ptr == LAST_W) r_out_valid <= 1'b0;
        r_out_ptr <= f_inc(r_out_ptr);
      end
      // accepted start consumes the loaded flags and drops any undrained result
      if (w_start_ok) begin
        r_loaded <= '0; r_mode <= i_mode; r_out_valid <= 1'b0; r_out_ptr <= '0;
      end
    end
  end

  // Operand stores: written by loads and by captured product words, never reset
  always_ff @(posedge clk) begin
    if (w_ld) begin
      case (i_in_sel)
        2'd0:    r_st_c[r_ld_ptr[0]] <= i_in_data;
        2'd1:    r_st_d[r_ld_ptr[1]] <= i_in_data;
        2'd2:    r_st_r[r_ld_ptr[2]] <= i_in_data;
        default: r_st_t[r_ld_ptr[3]] <= i_in_data;
      endcase
    end
    if (w_cap) begin
      if (r_op.dst_r1) r_st_x[r_res_ptr] <= i_mp_res;
      else             r_st_r[r_res_ptr] <= i_mp_res;
    end
  end
endmodule

// File: tb/tb_mod_exp_ladder_ctrl.sv
// Directed bench for mod_exp_ladder_ctrl with 8-bit words, 2 words per
// operand, n = 0x03E9, R = 2^16, and a behavioural Montgomery-product engine.
module tb_mod_exp_ladder_ctrl;
  localparam int WW = 8;
  localparam int NW = 2;
  localparam logic [47:0] N = 48'h3E9;

  logic          clk = 0, reset = 0;
  logic          in_valid, start, mode, out_ready, mp_res_valid;
  logic [1:0]    in_sel;
  logic [WW-1:0] in_data, mp_res;
  logic          in_ready, busy, err, out_valid, mp_start, mp_op_valid;
  logic [WW-1:0] out_data, mp_a, mp_b;

  int checks = 0, errors = 0;
  int cyc = 0, mp_starts = 0, gap2 = -1, last_res_cyc = 0;
  bit gap_mode = 0;

  mod_exp_ladder_ctrl #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_sel(in_sel), .i_in_data(in_data),
    .i_start(start), .i_mode(mode), .o_busy(busy), .o_err(err),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_mp_start(mp_start), .o_mp_op_valid(mp_op_valid), .o_mp_a(mp_a), .o_mp_b(mp_b),
    .i_mp_res_valid(mp_res_valid), .i_mp_res(mp_res)
  );

  always #5 clk = ~clk;

  // a*b*2^-16 mod n, bit-serial reduction
  function automatic logic [15:0] mont(input logic [15:0] a, input logic [15:0] b);
    logic [47:0] x;
    x = 48'(a) * 48'(b);
    for (int i = 0; i < 16; i++) begin
      if (x[0]) x = x + N;
      x = x >> 1;
    end
    if (x >= N) x = x - N;
    return x[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: gathers operand words, answers after the last one
  initial begin : mp_model
    int nw, pend, gc;
    logic [15:0] oa, ob, res;
    nw = 0; pend = 0; gc = 0; oa = '0; ob = '0; res = '0;
    mp_res_valid = 0; mp_res = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mp_res_valid = 0; mp_res = '0;
      if (reset) begin
        nw = 0; pend = 0;
      end else begin
        if (pend > 0) begin
          if (!gap_mode || (gc % 3) == 2) begin
            mp_res_valid = 1;
            mp_res = res[8*(NW-pend) +: 8];
            pend--;
            if (pend == 0) last_res_cyc = cyc;
          end
          gc++;
        end else if (gap_mode && mp_op_valid) begin
          mp_res_valid = 1; mp_res = 8'hFF;   // stray strobe, must be ignored
        end
        if (mp_start) begin
          mp_starts++; nw = 0;
          if (mp_starts == 2) gap2 = cyc - last_res_cyc;
        end
        if (mp_op_valid) begin
          oa[8*nw +: 8] = mp_a; ob[8*nw +: 8] = mp_b; nw++;
          if (nw == NW) begin res = mont(oa, ob); pend = NW; gc = 0; end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic load_word(input logic [1:0] s, input logic [7:0] w);
    in_valid = 1; in_sel = s; in_data = w;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic load16(input logic [1:0] s, input logic [15:0] v);
    load_word(s, v[7:0]);
    load_word(s, v[15:8]);
  endtask

  task automatic load_all(input logic [15:0] d);
    load16(2'd0, 16'h0002); load16(2'd1, d); load16(2'd2, 16'h01D7); load16(2'd3, 16'h026C);
  endtask

  task automatic run(input logic m, input bit mid, input string tag);
    int n;
    mp_starts = 0; gap2 = -1;
    mode = m; start = 1;
    @(posedge clk); #1; start = 0;
    chk({tag, "_busy_c1"}, busy, 1);
    chk({tag, "_mpstart_c1"}, mp_start, 1);
    chk({tag, "_inready_c1"}, in_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_opvalid_c2"}, mp_op_valid, 1);
    chk({tag, "_mpa_c2"}, mp_a, 8'h02);
    chk({tag, "_mpb_c2"}, mp_b, 8'h6C);
    if (mid) begin
      repeat (10) @(posedge clk);
      #1; start = 1;
      @(posedge clk); #1; start = 0;
      chk({tag, "_mid_err"}, err, 0);
      chk({tag, "_mid_busy"}, busy, 1);
    end
    n = 0;
    while (!out_valid && n < 2000) begin @(posedge clk); #1; n++; end
    chk({tag, "_done"}, out_valid, 1);
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  task automatic drain(input logic [15:0] exp, input bit tog, input string tag);
    if (!tog) begin
      out_ready = 1;
      chk({tag, "_w0"}, out_data, exp[7:0]);
      @(posedge clk); #1;
      chk({tag, "_w1"}, out_data, exp[15:8]);
      chk({tag, "_v1"}, out_valid, 1);
      @(posedge clk); #1;
      chk({tag, "_vend"}, out_valid, 0);
    end else begin
      out_ready = 0;
      chk({tag, "_w0"}, out_data, exp[7:0]);
      @(posedge clk); #1;
      chk({tag, "_w0_hold"}, out_data, exp[7:0]);
      out_ready = 1;
      @(posedge clk); #1;
      chk({tag, "_w1"}, out_data, exp[15:8]);
      out_ready = 0;
      @(posedge clk); #1;
      chk({tag, "_w1_hold"}, out_data, exp[15:8]);
      chk({tag, "_v_hold"}, out_valid, 1);
      out_ready = 1;
      @(posedge clk); #1;
      chk({tag, "_vend"}, out_valid, 0);
    end
    out_ready = 0;
    chk({tag, "_inready_done"}, in_ready, 1);
  endtask

  initial begin : stim
    int n;
    in_valid = 0; in_sel = 0; in_data = 0; start = 0; mode = 0; out_ready = 0;
    #1 reset = 1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mp_start", mp_start, 0);
    chk("rst_mp_op_valid", mp_op_valid, 0);
    chk("rst_mp_a", mp_a, 0);
    chk("rst_mp_b", mp_b, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    // start with only c and d loaded is rejected
    load16(2'd0, 16'h0002); load16(2'd1, 16'h000A);
    start = 1; mode = 0;
    @(posedge clk); #1; start = 0;
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("rej_err_clear", err, 0);

    // ladder, with an ignored start mid-run
    load16(2'd2, 16'h01D7); load16(2'd3, 16'h026C);
    run(1'b0, 1'b1, "lad");
    chk("lad_ops", mp_starts, 34);
    chk("lad_gap", gap2, 1);
    drain(16'h0017, 1'b0, "lad");

    // square-and-multiply
    load_all(16'h000A);
    run(1'b1, 1'b0, "sqm");
    chk("sqm_ops", mp_starts, 8);
    chk("sqm_scan_gap", gap2, 14);
    drain(16'h0017, 1'b0, "sqm");

    // zero exponent in both modes
    load_all(16'h0000);
    run(1'b1, 1'b0, "z1");
    chk("z1_ops", mp_starts, 2);
    drain(16'h0001, 1'b0, "z1");
    load_all(16'h0000);
    run(1'b0, 1'b0, "z0");
    chk("z0_ops", mp_starts, 34);
    drain(16'h0001, 1'b0, "z0");

    // gapped engine responses and a stalling consumer
    gap_mode = 1;
    load_all(16'h000A);
    run(1'b0, 1'b0, "gap");
    chk("gap_ops", mp_starts, 34);
    drain(16'h0017, 1'b1, "gap");
    gap_mode = 0;

    // reset while the first LAD_B op is in flight
    load_all(16'h000A);
    mp_starts = 0;
    mode = 0; start = 1;
    @(posedge clk); #1; start = 0;
    n = 0;
    while (mp_starts < 3 && n < 500) begin @(posedge clk); #1; n++; end
    chk("ladb_reached", (mp_starts >= 3), 1);
    @(posedge clk); #1;
    chk("ladb_busy_pre", busy, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_mp_start", mp_start, 0);
    chk("mid_rst_op_valid", mp_op_valid, 0);
    chk("mid_rst_mp_a", mp_a, 0);
    chk("mid_rst_mp_b", mp_b, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    load_all(16'h000A);
    run(1'b0, 1'b0, "rl");
    chk("rl_ops", mp_starts, 34);
    drain(16'h0017, 1'b0, "rl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_exp_ladder_ctrl.md
# mod_exp_ladder_ctrl

Parametrised modular-exponentiation controller computing c^d mod n in the Montgomery domain. It owns the operand stores and sequences an external word-serial Montgomery-product engine (mp_*). It supports a constant-time Montgomery-ladder mode and a fast square-and-multiply mode. Operands load, and the result drains, over valid/ready word streams. Those streams replace the fixed-size load/dump sequence of the previous generation.

## Interface
- WORD_W, 128: word width in bits.
- NUM_WORDS, 32: words per operand; EXP_BITS = WORD_W*NUM_WORDS.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  load word valid.
- in_ready  out  1  high in IDLE or DONE, otherwise low.
- in_sel  in  2  0=c, 1=d, 2=r (R mod n), 3=t (R^2 mod n).
- in_data  in  WORD_W  operand word, LSW first.
- start  in  1  one-cycle start pulse.
- mode  in  1  0=ladder, 1=square-and-multiply; latched at start.
- busy  out  1  high from accepted start until DONE.
- err  out  1  one-cycle pulse when start is rejected.
- out_valid  out  1  result word valid.
- out_ready  in  1  result word accepted.
- out_data  out  WORD_W  result word, LSW first.
- mp_start  out  1  one-cycle pulse beginning a Montgomery product.
- mp_op_valid  out  1  high for NUM_WORDS cycles carrying operand word pairs.
- mp_a, mp_b  out  WORD_W each  operand words, same index, LSW first.
- mp_res_valid  in  1  result word strobe; may be gapped.
- mp_res  in  WORD_W  result word, LSW first.

## Operation
- Load:
  - Each in_valid&&in_ready transfer writes in_sel's store at a per-selector word pointer, then increments that pointer.
  - At NUM_WORDS the pointer wraps to 0 and sets loaded[in_sel].
  - A change of in_sel does not reset the other pointers.
- Start:
  - start is accepted in IDLE or DONE only when all four loaded bits are set.
  - Otherwise start pulses err and the state is unchanged.
  - start while busy is ignored, with no err pulse.
  - Accepted start clears the loaded bits; operand contents are retained.
- Product op: mp_start for 1 cycle, then NUM_WORDS cycles of mp_op_valid, then capture each mp_res_valid word into the destination at the result pointer. The op completes at NUM_WORDS captured words. Any mp_res_valid outside the capture window is ignored.
- States: IDLE -> CBAR -> (mode 0: LAD_A -> LAD_B loop | mode 1: SCAN -> SQR -> [MUL] loop) -> CONV -> DONE.
  - CBAR: cbar = MP(c, t); R0 = r copied in the same pass.
  - Ladder: for i = EXP_BITS-1 down to 0, with b = d[i]:
    - LAD_A: R(1-b) = MP(R0, R1).
    - LAD_B: R(b) = MP(R(b), R(b)).
    - R1 is initialised to cbar. No leading-zero skipping; every exponent costs exactly 2*EXP_BITS ops.
  - SCAN: bit index starts at EXP_BITS-1 and decrements one bit per cycle until d[i]=1. If no set bit is found, go to CONV with R0 = r.
  - Square-and-multiply: for each i from the leading one down to 0:
    - SQR: R0 = MP(R0, R0).
    - MUL (only if d[i]=1): R0 = MP(R0, cbar).
  - CONV: R0 = MP(R0, 1), where b is 1 in word 0 and 0 elsewhere.
  - DONE: out_valid high, out_data = R0[out_ptr]. On out_ready, out_ptr increments. After the last word, out_valid drops and the block stays in DONE (in_ready=1) until the next start.
- A new accepted start from DONE discards any undrained result.
- The result R0 of the last completed run stays readable only until the next load of r: R0 aliases the r store.

## Timing
- Reset values: in_ready=0 during reset, then 1 in IDLE; busy=0, err=0, out_valid=0, out_data=0, mp_start=0, mp_op_valid=0, mp_a=0, mp_b=0. State is IDLE, all pointers are 0, all loaded bits are 0.
- Reset mid-operation aborts immediately to the reset values. Stores are not cleared.
- Start accepted at cycle 0: busy=1 and the CBAR mp_start both occur at cycle 1. mp_op_valid covers cycles 2..NUM_WORDS+1.
- Next op: mp_start follows 1 cycle after the final result word of the previous op. CONV completion -> out_valid at the next cycle.
- Op counts:
  - Ladder: 2*EXP_BITS + 2 ops.
  - Square-and-multiply: 2 + (L+1) + popcount(d), where L is the leading-one index. If d=0, 2 ops.
- Bit indexing: d[i] = dstore[i/WORD_W][i%WORD_W]. The index counter is clog2(EXP_BITS) bits wide and never wraps below 0.

## Test plan
- Params WORD_W=8, NUM_WORDS=2; behavioural MP model; n=0x03E9. Load c=0x0002, d=0x000A, r=0x01D7, t=0x026C; mode 0 -> result words 0x17, 0x00; exactly 34 mp_start pulses.
- Same operands, mode 1 -> result 0x0017 with 8 mp_start pulses; SCAN takes 13 cycles.
- d=0x0000 in both modes -> result 0x0001; mode 1 uses 2 ops and mode 0 uses 34.
- start with only c and d loaded -> err for 1 cycle, busy stays 0. A mid-run start has no effect and no err.
- Reset asserted during LAD_B -> all outputs return to reset values within the cycle. Reload all four operands and restart -> correct result 0x0017.
- Drain with out_ready toggling 1,0,1 -> words 0x17 then 0x00, each held stable while out_ready=0. Gapped mp_res_valid (1 of 3 cycles) produces an identical result.
